// File: rtl/cl_mux2_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// cl_mux2_rr_arb_pkg
// Shared definitions for the two-input round-robin output mux:
//   - arb_state_e : FSM state encoding (IDLE / HOLD0 / HOLD1)
//   - SEL_*       : one-hot source codes used for both the winner and o_sel
//   - GRANT_*     : encoding of the last_grant history bit
//   - state_to_sel: maps an FSM state to its one-hot o_sel code
// ----------------------------------------------------------------------------
package cl_mux2_rr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD0 = 2'b01,
    ST_HOLD1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_0    = 2'b01;
  localparam logic [1:0] SEL_1    = 2'b10;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  // One-hot source code that o_sel carries while the FSM sits in a state.
  function automatic logic [1:0] state_to_sel(input arb_state_e st);
    logic [1:0] sel;
    case (st)
      ST_HOLD0: sel = SEL_0;
      ST_HOLD1: sel = SEL_1;
      ST_IDLE:  sel = SEL_NONE;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cl_rr_pick2.sv
// ----------------------------------------------------------------------------
// cl_rr_pick2
// Purely combinational two-way round-robin winner selection.
// Ports:
//   req0_valid, req1_valid : requester valids
//   last_grant             : requester granted most recently (GRANT_REQ0/1)
//   winner                 : one-hot winner (SEL_0 / SEL_1 / SEL_NONE)
//   any_valid              : at least one requester is valid
// ----------------------------------------------------------------------------
module cl_rr_pick2
  import cl_mux2_rr_arb_pkg::*;
(
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic       last_grant,
  output logic [1:0] winner,
  output logic       any_valid
);

  logic [1:0] winner_s;

  // Winner decode: a lone requester always wins; on contention the side
  // that was not granted last time wins.
  always_comb begin
    winner_s = SEL_NONE;
    case ({req1_valid, req0_valid})
      2'b01:   winner_s = SEL_0;
      2'b10:   winner_s = SEL_1;
      2'b11: begin
        if (last_grant == GRANT_REQ1) begin
          winner_s = SEL_0;
        end else begin
          winner_s = SEL_1;
        end
      end
      default: winner_s = SEL_NONE;
    endcase
  end

  assign winner    = winner_s;
  assign any_valid = req0_valid | req1_valid;

endmodule

// File: rtl/cl_mux2_rr_arb.sv
// ----------------------------------------------------------------------------
// cl_mux2_rr_arb
// Two requesters share one registered output stage. A round-robin picker
// chooses the source; the output register is refilled whenever it is empty
// or being drained, giving one transfer per cycle under a ready downstream.
// Ports:
//   i_clk, i_rst_n               : clock, async active-low reset
//   i_req0_valid/data, o_req0_ready : requester 0 handshake
//   i_req1_valid/data, o_req1_ready : requester 1 handshake
//   o_valid, o_data, i_ready     : output handshake (registered data)
//   o_sel                        : one-hot source of o_data (00 when empty)
//   o_xfer_cnt                   : wrapping count of output handshakes
// ----------------------------------------------------------------------------
module cl_mux2_rr_arb
  import cl_mux2_rr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  output logic                  o_req1_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_sel,
  output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

  arb_state_e            state_r;
  arb_state_e            state_nxt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] data_nxt_s;
  logic [1:0]            sel_r;
  logic [1:0]            sel_nxt_s;
  logic                  valid_r;
  logic                  valid_nxt_s;
  logic                  last_grant_r;
  logic                  last_grant_nxt_s;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [1:0]            winner_s;
  logic                  any_valid_s;
  logic                  acc_s;
  logic [DATA_WIDTH-1:0] pick_data_s;

  cl_rr_pick2 u_pick (
    .req0_valid (i_req0_valid),
    .req1_valid (i_req1_valid),
    .last_grant (last_grant_r),
    .winner     (winner_s),
    .any_valid  (any_valid_s)
  );

  // Accept decode: an empty register always accepts, a full one only when
  // the downstream drains it in the same cycle.
  always_comb begin
    acc_s = 1'b1;
    case (state_r)
      ST_IDLE:  acc_s = 1'b1;
      ST_HOLD0: acc_s = i_ready;
      ST_HOLD1: acc_s = i_ready;
      default:  acc_s = 1'b1;
    endcase
  end

  // One-hot payload select; with no winner both terms mask to zero.
  assign pick_data_s = ({DATA_WIDTH{winner_s[0]}} & i_req0_data) |
                       ({DATA_WIDTH{winner_s[1]}} & i_req1_data);

  // Readies are gated by reset so nothing is accepted while held in reset.
  assign o_req0_ready = i_rst_n & acc_s & winner_s[0];
  assign o_req1_ready = i_rst_n & acc_s & winner_s[1];

  // Next-state / next-output logic: refill on accept, otherwise hold.
  always_comb begin
    state_nxt_s      = state_r;
    data_nxt_s       = data_r;
    last_grant_nxt_s = last_grant_r;
    if (acc_s) begin
      if (any_valid_s) begin
        data_nxt_s = pick_data_s;
        if (winner_s[1]) begin
          state_nxt_s      = ST_HOLD1;
          last_grant_nxt_s = GRANT_REQ1;
        end else begin
          state_nxt_s      = ST_HOLD0;
          last_grant_nxt_s = GRANT_REQ0;
        end
      end else begin
        state_nxt_s = ST_IDLE;
        data_nxt_s  = {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_nxt_s = state_r;
    end
    sel_nxt_s   = state_to_sel(state_nxt_s);
    valid_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers; reset prefers req0 on first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      data_r       <= {DATA_WIDTH{1'b0}};
      sel_r        <= SEL_NONE;
      valid_r      <= 1'b0;
      last_grant_r <= GRANT_REQ1;
    end else begin
      state_r      <= state_nxt_s;
      data_r       <= data_nxt_s;
      sel_r        <= sel_nxt_s;
      valid_r      <= valid_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Handshake counter; wraps naturally at its width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (valid_r && i_ready) begin
      cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_valid    = valid_r;
  assign o_data     = data_r;
  assign o_sel      = sel_r;
  assign o_xfer_cnt = cnt_r;

endmodule

// File: tb/tb_cl_mux2_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_cl_mux2_rr_arb
// Self-checking bench: each accepted request pushes its expected output word
// onto a queue; the word is popped and compared once the register updates.
// ----------------------------------------------------------------------------
module tb_cl_mux2_rr_arb;

  localparam int DW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          ready;
  logic [1:0]    sel;
  logic [CW-1:0] xfer_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW+1:0] exp_q[$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_sel;
  logic          m_last;
  logic [CW-1:0] m_cnt;

  cl_mux2_rr_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .i_req0_data  (req0_data),
    .o_req0_ready (req0_ready),
    .i_req1_valid (req1_valid),
    .i_req1_data  (req1_data),
    .o_req1_ready (req1_ready),
    .o_valid      (out_valid),
    .o_data       (out_data),
    .i_ready      (ready),
    .o_sel        (sel),
    .o_xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 2'b00;
    m_last  = 1'b1;
    m_cnt   = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    check_eq({tag, "_data"},  32'(out_data),  32'(m_data));
    check_eq({tag, "_sel"},   32'(sel),       32'(m_sel));
    check_eq({tag, "_cnt"},   32'(xfer_cnt),  32'(m_cnt));
  endtask

  task automatic step(input logic v0, input logic [DW-1:0] d0,
                      input logic v1, input logic [DW-1:0] d1,
                      input logic rdy, input string tag);
    logic          acc;
    logic          w0;
    logic          w1;
    logic [DW+1:0] e;
    @(negedge clk);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    ready      = rdy;
    #1;
    acc = !m_valid || rdy;
    w0  = v0 && (!v1 || m_last);
    w1  = v1 && (!v0 || !m_last);
    check_eq({tag, "_rdy0"}, 32'(req0_ready), 32'(acc && w0));
    check_eq({tag, "_rdy1"}, 32'(req1_ready), 32'(acc && w1));
    if (m_valid && rdy) m_cnt = m_cnt + 8'd1;
    if (acc) begin
      if (w0) begin
        exp_q.push_back({d0, 2'b01});
        m_last = 1'b0;
      end else if (w1) begin
        exp_q.push_back({d1, 2'b10});
        m_last = 1'b1;
      end else begin
        exp_q.push_back({{DW{1'b0}}, 2'b00});
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      e       = exp_q.pop_front();
      m_data  = e[DW+1:2];
      m_sel   = e[1:0];
      m_valid = (e[1:0] != 2'b00);
    end
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ready      = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    check_eq("rst_rdy0", 32'(req0_ready), 32'd0);
    check_eq("rst_rdy1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    ready      = 1'b0;
    model_reset();
    #2;
    apply_reset();

    // single request, then drain into IDLE
    step(1'b1, 5'h0A, 1'b0, 5'h00, 1'b1, "single");
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, "drain");
    check_eq("drain_idle_sel", 32'(sel), 32'd0);
    check_eq("drain_cnt1", 32'(xfer_cnt), 32'd1);

    // continuous contention: 01,02,01,02 with no bubbles
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'h01, 1'b1, 5'h02, 1'b1, "contend");
      check_eq("contend_data", 32'(out_data), (i % 2 == 0) ? 32'h01 : 32'h02);
    end

    // backpressure: hold req1 word while req0 waits
    step(1'b0, 5'h00, 1'b1, 5'h11, 1'b1, "load1");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'h07, 1'b0, 5'h00, 1'b0, "hold");
      check_eq("hold_data", 32'(out_data), 32'h11);
    end
    step(1'b1, 5'h07, 1'b0, 5'h00, 1'b1, "release");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           DW'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    // asynchronous reset while holding a req0 word
    step(1'b1, 5'h15, 1'b0, 5'h00, 1'b1, "pre_rst");
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b0, "pre_rst_hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // counter wrap at 255 -> 0
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, DW'(i), 1'b0, 5'h00, 1'b1, "fill");
    end
    check_eq("cnt_at_255", 32'(xfer_cnt), 32'd255);
    step(1'b0, 5'h00, 1'b0, 5'h00, 1'b1, "wrap");
    check_eq("cnt_wrap", 32'(xfer_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
